game_turn_ctrl: RTL

//  Turn sequencer for the 8x8 board. Accepts move requests and arbitrates the board RAM write port.

---
 rtl/game_turn_ctrl.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/game_turn_ctrl.sv
// rtl/game_turn_ctrl.sv - turn sequencer for the 8x8 board: clear sweep, judge, commit, win/draw detect
// Optional feature macro: TURN_TIMEOUT_EN (per-turn idle timeout with forfeit of the move)

`ifndef JUDGER_INVALID
`define JUDGER_INVALID 2'd0
`endif
`ifndef JUDGER_VALID
`define JUDGER_VALID 2'd1
`endif
`ifndef JUDGER_WIN
`define JUDGER_WIN 2'd2
`endif
`ifndef SIDE_RED
`define SIDE_RED 1'b0
`endif
`ifndef SIDE_GREEN
`define SIDE_GREEN 1'b1
`endif

module game_turn_ctrl #(
    parameter int BOARD_CELLS  = 64,
    parameter int TURN_TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       new_game,
    input  logic       move_valid,
    input  logic [5:0] move_pos,
    output logic       move_ready,
    output logic       move_ack,
    output logic [1:0] move_status,
    output logic       cur_side,
    output logic       judger_en,
    output logic       judger_color,
    output logic [5:0] judger_pos,
    input  logic [1:0] judger_result,
    input  logic       judger_done,
    output logic       ram_wr_en,
    output logic [5:0] ram_wr_addr,
    output logic [1:0] ram_wr_data,
    output logic       game_over,
    output logic       winner_valid,
    output logic       winner,
    output logic       timeout_pulse
);

    typedef enum logic [2:0] {
        S_CLEAR   = 3'd0,
        S_IDLE    = 3'd1,
        S_JUDGE   = 3'd2,
        S_WRITE   = 3'd3,
        S_RELEASE = 3'd4,
        S_OVER    = 3'd5
    } state_t;

    localparam logic [5:0] CLR_LAST = 6'(BOARD_CELLS - 1);
    localparam logic [6:0] CELLS    = 7'(BOARD_CELLS);

    state_t     r_state;
    state_t     w_next;
    logic [5:0] r_clr_addr;
    logic       r_cur_side;
    logic       r_side_lat;
    logic [5:0] r_pos;
    logic [1:0] r_result;
    logic [6:0] r_move_cnt;
    logic       r_inv_ack;
    logic       r_winner_valid;
    logic       r_winner;

    logic       w_accept;
    logic       w_timeout;
    logic       w_clr_last;
    logic       w_board_full;

    assign w_accept     = (r_state == S_IDLE) && move_valid && !judger_done;
    assign w_clr_last   = (r_clr_addr == CLR_LAST);
    assign w_board_full = ((r_move_cnt + 7'd1) == CELLS);

`ifdef TURN_TIMEOUT_EN
    localparam int TO_W = (TURN_TIMEOUT > 1) ? $clog2(TURN_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TURN_TIMEOUT - 1);

    logic [TO_W-1:0] r_to_cnt;

    // Counter only advances while waiting in S_IDLE, so every idle entry starts a fresh turn budget
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (new_game || (r_state != S_IDLE) || w_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    assign w_timeout = (r_state == S_IDLE) && (r_to_cnt == TO_LAST) && !w_accept;
`else
    // Timeouts disabled: turns wait indefinitely
    assign w_timeout = (TURN_TIMEOUT < 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (new_game) begin
            w_next = S_CLEAR;
        end else begin
            case (r_state)
                S_CLEAR:   if (w_clr_last) w_next = S_IDLE;
                S_IDLE:    if (w_accept) w_next = S_JUDGE;
                S_JUDGE: begin
                    if (judger_done) begin
                        w_next = (judger_result == `JUDGER_INVALID) ? S_RELEASE : S_WRITE;
                    end
                end
                S_WRITE: begin
                    if ((r_result == `JUDGER_WIN) || w_board_full) w_next = S_OVER;
                    else w_next = S_RELEASE;
                end
                S_RELEASE: w_next = S_IDLE;
                S_OVER:    w_next = S_OVER;
                default:   w_next = S_CLEAR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clr_addr     <= 6'd0;
            r_cur_side     <= `SIDE_RED;
            r_side_lat     <= `SIDE_RED;
            r_pos          <= 6'd0;
            r_result       <= `JUDGER_INVALID;
            r_move_cnt     <= 7'd0;
            r_inv_ack      <= 1'b0;
            r_winner_valid <= 1'b0;
            r_winner       <= 1'b0;
        end else if (new_game) begin
            r_clr_addr     <= 6'd0;
            r_cur_side     <= `SIDE_RED;
            r_result       <= `JUDGER_INVALID;
            r_move_cnt     <= 7'd0;
            r_inv_ack      <= 1'b0;
            r_winner_valid <= 1'b0;
            r_winner       <= 1'b0;
        end else begin
            r_inv_ack <= 1'b0;
            case (r_state)
                S_CLEAR: begin
                    r_clr_addr <= w_clr_last ? 6'd0 : (r_clr_addr + 6'd1);
                end
                S_IDLE: begin
                    if (w_accept) begin
                        r_pos      <= move_pos;
                        r_side_lat <= r_cur_side;
                    end else if (w_timeout) begin
                        r_cur_side <= ~r_cur_side;
                    end
                end
                S_JUDGE: begin
                    if (judger_done) begin
                        r_result  <= judger_result;
                        r_inv_ack <= (judger_result == `JUDGER_INVALID);
                    end
                end
                S_WRITE: begin
                    r_move_cnt <= r_move_cnt + 7'd1;
                    if (r_result == `JUDGER_WIN) begin
                        r_winner_valid <= 1'b1;
                        r_winner       <= r_side_lat;
                    end else if (!w_board_full) begin
                        r_cur_side <= ~r_side_lat;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Rejected moves acknowledge from a register so the ack still trails judger_done by one cycle
    always_comb begin
        move_ready  = 1'b0;
        move_ack    = r_inv_ack;
        judger_en   = 1'b0;
        ram_wr_en   = 1'b0;
        ram_wr_addr = r_clr_addr;
        ram_wr_data = 2'b00;
        game_over   = 1'b0;
        case (r_state)
            S_CLEAR: ram_wr_en = 1'b1;
            S_IDLE:  move_ready = !judger_done;
            S_JUDGE: judger_en = 1'b1;
            S_WRITE: begin
                judger_en   = 1'b1;
                ram_wr_en   = 1'b1;
                ram_wr_addr = r_pos;
                ram_wr_data = (r_side_lat == `SIDE_RED) ? 2'b10 : 2'b01;
                move_ack    = 1'b1;
            end
            S_OVER:  game_over = 1'b1;
            default: begin
            end
        endcase
    end

    assign move_status   = r_result;
    assign cur_side      = r_cur_side;
    assign judger_color  = r_side_lat;
    assign judger_pos    = r_pos;
    assign winner_valid  = r_winner_valid;
    assign winner        = r_winner;
    assign timeout_pulse = w_timeout;

endmodule
